csa_resolve: RTL and testbench
==============================

// Module: csa_resolve
// PURPOSE
//  Resolves a carry-save pair (C,S) from the CSA/FA array into a plain binary value, R = S + (C << 1).
//  Digit-serial carry-propagate adder: DIGIT bits per cycle, with a registered carry between digits.
//  Sits at the output of the CSA tree. Handshake on both sides.
// PARAMETERS
//  WIDTH   23  width of each carry-save operand C and S (C[i] has weight 2^(i+1))
//  DIGIT   8   bits resolved per RUN cycle
//  Derived, localparam: RW = WIDTH+2 (result width); ND = ceil(RW/DIGIT) (digits per operation)
// PORTS
//  clk        in   1      clock; all logic on the rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      C/S operand pair is valid
//  in_ready   out  1      block can accept an operand pair
//  in_c       in   WIDTH  carry vector from the CSA
//  in_s       in   WIDTH  sum vector from the CSA
//  out_valid  out  1      out_r holds a resolved result
//  out_ready  in   1      downstream accepts the result
//  out_r      out  RW     S + 2*C, exact with no overflow
//  out_zero   out  1      result == 0 (only when CSA_RESOLVE_ZERO_EN is defined)
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_r=0, out_zero=0, digit counter=0, carry=0.
//  - FSM:
//    - IDLE -> RUN on in_valid&&in_ready. Capture A={2'b0,in_s} and B={1'b0,in_c,1'b0}, zero-padded to ND*DIGIT bits.
//    - At capture: cnt=0, carry=0.
//    - RUN: each cycle, sum = A[cnt] + B[cnt] + carry over DIGIT bits. Store the digit in result slice cnt; carry <= sum carry-out; cnt++.
//    - RUN -> DONE on the cycle that processes cnt==ND-1. The final carry-out is provably 0 and is discarded.
//    - DONE: out_valid=1. out_r is stable until the handshake. DONE -> IDLE on out_ready.
//  - in_ready=1 only in IDLE. in_valid is ignored in RUN and DONE; operands are not re-sampled.
//  - Latency: out_valid rises exactly ND clock edges after the accept edge (4 for defaults).
//    Minimum issue interval: ND+2 cycles.
//  - out_ready may be held high before out_valid. The handshake completes on the first cycle with out_valid&&out_ready.
//  - Backpressure: out_ready low holds DONE indefinitely. out_r, out_valid and out_zero do not change.
//  - The last digit may be partial (RW not a multiple of DIGIT). Pad bits are 0, and out_r takes the low RW bits.
//  - Reset mid-operation (RUN or DONE): result discarded; all outputs return to reset values on the next edge.
//  - out_r is registered and updated digit-by-digit in RUN. It is valid only while out_valid=1.
//  - No X propagation: C/S are sampled only at accept.
// CONFIGURATION
//  - CSA_RESOLVE_ZERO_EN defined:
//    - Port out_zero exists and a sticky nonzero flag is kept: cleared at accept, set by any nonzero digit in RUN.
//    - out_zero = ~flag in DONE, 0 otherwise.
//  - Not defined: port out_zero and the flag logic are absent. All other behaviour is identical.
// TESTING (WIDTH=23, DIGIT=8, ND=4)
//  1. After reset:
//     - in_ready=1, out_valid=0, out_r=0.
//     - in_c=0, in_s=0x000001 accepted -> out_valid exactly 4 edges later, out_r=0x0000001.
//  2. in_c=0x7FFFFF, in_s=0x7FFFFF -> out_r=0x17FFFFD (max value, top bit exercised, no overflow).
//  3. in_c=0x000001, in_s=0x0000FF -> out_r=0x0000101 (carry crosses the digit 0/1 boundary).
//  4. Hold out_ready=0 for 5 cycles in DONE:
//     - out_valid stays 1, out_r is unchanged, in_ready=0.
//     - A second in_valid pulse is ignored.
//     - Then out_ready=1 -> IDLE.
//  5. Assert rst_n=0 for one cycle during RUN with cnt=2:
//     - Next state IDLE, out_valid=0, out_r=0.
//     - A following op in_c=0x000010, in_s=0x000020 -> out_r=0x0000040.
//  6. Hold in_valid=1 with out_ready=1 over 3 random ops:
//     - Each result matches s+2c.
//     - Ops are accepted every 6 cycles.
//     - With CSA_RESOLVE_ZERO_EN: in_c=0, in_s=0 -> out_zero=1, and out_zero=0 for every nonzero case.

Source files
------------

// File: rtl/csa_resolve.sv
// Digit-serial carry-propagate adder resolving a carry-save pair into R = S + 2*C.
// Optional zero flag output is enabled with `define CSA_RESOLVE_ZERO_EN.
module csa_resolve #(
    parameter  int WIDTH = 23,
    parameter  int DIGIT = 8,
    localparam int RW    = WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_r
`ifdef CSA_RESOLVE_ZERO_EN
    ,
    output logic             out_zero
`endif
);
    localparam int ND = (RW + DIGIT - 1) / DIGIT;
    localparam int PW = ND * DIGIT;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, next_state;
    logic [PW-1:0]  a_q, b_q, res_q;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           accept;
    logic           last;
    logic [DIGIT:0] sum;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(ND - 1));
    assign sum    = {1'b0, a_q[cnt*DIGIT +: DIGIT]}
                  + {1'b0, b_q[cnt*DIGIT +: DIGIT]}
                  + {{DIGIT{1'b0}}, carry};
    assign out_r  = res_q[RW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: operand registers are not reset; they are always loaded at accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= {{(PW-WIDTH){1'b0}}, in_s};
            b_q <= {{(PW-WIDTH-1){1'b0}}, in_c, 1'b0};
        end
    end

    // The final carry-out cannot be set for S + 2*C within RW bits, so it is simply left behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            res_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= 1'b0;
        end else if (state == RUN) begin
            res_q[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
            carry                     <= sum[DIGIT];
            cnt                       <= cnt + 1'b1;
        end
    end

    generate
        if (PW > RW) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^res_q[PW-1:RW];
        end
    endgenerate

`ifdef CSA_RESOLVE_ZERO_EN
    logic nz_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nz_q <= 1'b0;
        end else if (accept) begin
            nz_q <= 1'b0;
        end else if (state == RUN && sum[DIGIT-1:0] != '0) begin
            nz_q <= 1'b1;
        end
    end

    assign out_zero = (state == DONE) && !nz_q;
`endif

endmodule

// File: tb/tb_csa_resolve.sv
// Scoreboard bench for csa_resolve: stimulus pushes expected results, a monitor pops them at each output handshake.
// Compile with +define+CSA_RESOLVE_ZERO_EN to also check out_zero.
module tb_csa_resolve;
    localparam int WIDTH = 23;
    localparam int DIGIT = 8;
    localparam int RW    = WIDTH + 2;
    localparam int ND    = 4;

    typedef struct {
        logic [RW-1:0] r;
        logic          z;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_c = '0;
    logic [WIDTH-1:0] in_s = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [RW-1:0]    out_r;
`ifdef CSA_RESOLVE_ZERO_EN
    logic             out_zero;
`endif

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [WIDTH-1:0] vc [4] = '{23'h123456, 23'h400000, 23'h0AAAAA, 23'h000000};
    logic [WIDTH-1:0] vs [4] = '{23'h654321, 23'h7FFFFF, 23'h555555, 23'h000000};
    logic [RW-1:0]    vr [4] = '{25'h089ABCD, 25'h0FFFFFF, 25'h06AAAA9, 25'h0000000};

    csa_resolve #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
`ifdef CSA_RESOLVE_ZERO_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every completed output handshake against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", out_r);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", out_r, e.r);
`ifdef CSA_RESOLVE_ZERO_EN
                check("out_zero", out_zero, e.z);
`endif
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s, input logic [RW-1:0] r);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("in_ready_before_send", in_ready, 1);
        in_c     = c;
        in_s     = s;
        in_valid = 1'b1;
        exp_q.push_back('{r: r, z: (r == '0)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("latency", k, ND);
    endtask

    task automatic op(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s, input logic [RW-1:0] r);
        send(c, s, r);
        wait_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_handshake", out_valid, 0);
        check("in_ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        int idx;
        int cyc;
        int last_acc;

        // 1. reset state and a first trivial op
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_r", out_r, 0);
`ifdef CSA_RESOLVE_ZERO_EN
        check("reset_out_zero", out_zero, 0);
`endif
        op(23'h000000, 23'h000001, 25'h0000001);

        // 2. maximum operands, 3. carry across digit 0/1
        op(23'h7FFFFF, 23'h7FFFFF, 25'h17FFFFD);
        op(23'h000001, 23'h0000FF, 25'h0000101);

        // 4. backpressure in DONE with a stray in_valid pulse
        send(23'h000F0F, 23'h00F0F0, 25'h0010F0E);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out_r", out_r, 25'h0010F0E);
            check("hold_in_ready", in_ready, 0);
            if (i == 1) begin
                in_c     = 23'h7FFFFF;
                in_s     = 23'h7FFFFF;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_after_hold_in_ready", in_ready, 1);
            check("idle_after_hold_out_valid", out_valid, 0);
            tick();
        end

        // 5. reset while RUN has cnt == 2
        send(23'h111111, 23'h222222, 25'h0444444);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("midrun_reset_out_valid", out_valid, 0);
        check("midrun_reset_out_r", out_r, 0);
        check("midrun_reset_in_ready", in_ready, 1);
        op(23'h000010, 23'h000020, 25'h0000040);

        // 6. back-to-back ops with in_valid and out_ready held high
        out_ready = 1'b1;
        in_c      = vc[0];
        in_s      = vs[0];
        in_valid  = 1'b1;
        idx       = 0;
        cyc       = 0;
        last_acc  = 0;
        while (idx < 4 && cyc < 100) begin
            if (in_ready) begin
                exp_q.push_back('{r: vr[idx], z: (vr[idx] == '0)});
                if (idx > 0) check("issue_interval", cyc - last_acc, 6);
                last_acc = cyc;
                idx++;
                tick();
                cyc++;
                if (idx < 4) begin
                    in_c = vc[idx];
                    in_s = vs[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                tick();
                cyc++;
            end
        end
        check("accepted_ops", idx, 4);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        out_ready = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
